// File: rtl/prbs_err_monitor_if.sv
// Lane error strobes, link status and control into the PRBS monitor; counts, lock and LED flags out.
interface prbs_err_monitor_if #(
  parameter int NLANES = 8,
  parameter int CNT_W  = 16
);
  logic [0:NLANES-1] PRBS_error;
  logic [0:3]        state_status;
  logic              clear;
  logic [2:0]        sel_lane;
  logic [CNT_W-1:0]  err_count;
  logic [0:NLANES-1] lane_locked;
  logic [0:NLANES-1] led_fp;

  modport master (
    output PRBS_error, state_status, clear, sel_lane,
    input  err_count, lane_locked, led_fp
  );

  modport slave (
    input  PRBS_error, state_status, clear, sel_lane,
    output err_count, lane_locked, led_fp
  );
endinterface

// File: rtl/prbs_err_monitor.sv
// Per-lane PRBS lock tracker (IDLE/HUNT/LOCKED) with saturating error counters and LED drive.
// LED_ERR_STRETCH_EN: blank a lane's LED for 2**STRETCH_W-1 cycles after each locked error.
module prbs_err_monitor #(
  parameter int         NLANES     = 8,
  parameter int         CNT_W      = 16,
  parameter int         LOCK_CNT   = 255,
  parameter logic [3:0] READY_CODE = 4'h3,
  parameter int         STRETCH_W  = 22
) (
  input  logic              txusrclk2,
  input  logic              reset,
  prbs_err_monitor_if.slave bus
);
  localparam int CLEAN_W = $clog2(LOCK_CNT + 1);
  localparam logic [CLEAN_W-1:0] LOCK_V = CLEAN_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_e;

  state_e             state_q [NLANES];
  state_e             state_d [NLANES];
  logic [CLEAN_W-1:0] clean_q [NLANES];
  logic [CLEAN_W-1:0] clean_d [NLANES];
  logic [CNT_W-1:0]   cnt_q   [NLANES];
  logic [CNT_W-1:0]   cnt_d   [NLANES];
  logic [0:NLANES-1]  lane_locked_q;
  logic [0:NLANES-1]  led_q;
  logic [CNT_W-1:0]   err_count_q;
  logic [CNT_W-1:0]   err_count_d;
  logic               link_ready;

  assign link_ready = (bus.state_status == READY_CODE);

  always_ff @(posedge txusrclk2) begin
    if (reset) begin
      for (int i = 0; i < NLANES; i++) begin
        state_q[i] <= IDLE;
        clean_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      clean_q <= clean_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      state_d[i] = state_q[i];
      clean_d[i] = clean_q[i];
      if (!link_ready) begin
        state_d[i] = IDLE;
        clean_d[i] = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            state_d[i] = HUNT;
            clean_d[i] = '0;
          end
          HUNT: begin
            if (bus.PRBS_error[i]) begin
              clean_d[i] = '0;
            end else if (clean_q[i] == LOCK_V) begin
              state_d[i] = LOCKED;
            end else begin
              clean_d[i] = clean_q[i] + 1'b1;
            end
          end
          LOCKED: state_d[i] = LOCKED;
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  // A clear coinciding with a locked error keeps that error.
  always_comb begin
    logic [CNT_W-1:0] base;
    base        = '0;
    err_count_d = '0;
    for (int i = 0; i < NLANES; i++) begin
      base     = bus.clear ? '0 : cnt_q[i];
      cnt_d[i] = base;
      if (state_q[i] == LOCKED && bus.PRBS_error[i] && base != '1) begin
        cnt_d[i] = base + 1'b1;
      end
      if (int'(bus.sel_lane) == i) begin
        err_count_d = cnt_q[i];
      end
    end
  end

  always_ff @(posedge txusrclk2) begin
    if (reset) begin
      for (int i = 0; i < NLANES; i++) begin
        cnt_q[i]         <= '0;
        lane_locked_q[i] <= 1'b0;
      end
      err_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      for (int i = 0; i < NLANES; i++) begin
        lane_locked_q[i] <= (state_q[i] == LOCKED);
      end
    end
  end

`ifdef LED_ERR_STRETCH_EN
  logic [STRETCH_W-1:0] timer_q [NLANES];
  logic [STRETCH_W-1:0] timer_d [NLANES];

  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      timer_d[i] = timer_q[i];
      if (state_q[i] == LOCKED && bus.PRBS_error[i]) begin
        timer_d[i] = '1;
      end else if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge txusrclk2) begin
    if (reset) begin
      for (int i = 0; i < NLANES; i++) begin
        timer_q[i] <= '0;
        led_q[i]   <= 1'b0;
      end
    end else begin
      timer_q <= timer_d;
      for (int i = 0; i < NLANES; i++) begin
        led_q[i] <= lane_locked_q[i] & (timer_q[i] == '0);
      end
    end
  end
`else
  always_ff @(posedge txusrclk2) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      led_q <= lane_locked_q;
    end
  end
`endif

  assign bus.err_count   = err_count_q;
  assign bus.lane_locked = lane_locked_q;
  assign bus.led_fp      = led_q;
endmodule

// File: tb/tb_prbs_err_monitor.sv
// Directed bench for prbs_err_monitor: lane-level behavioural model compared every cycle plus literal spot checks.
module tb_prbs_err_monitor;
  localparam int NL    = 8;
  localparam int CW    = 4;
  localparam int LOCK  = 255;
  localparam int SW    = 4;
  localparam int MAXC  = (1 << CW) - 1;
  localparam int BLANK = (1 << SW) - 1;

  logic txusrclk2 = 1'b0;
  logic reset     = 1'b1;

  prbs_err_monitor_if #(.NLANES(NL), .CNT_W(CW)) bus ();

  prbs_err_monitor #(
    .NLANES(NL), .CNT_W(CW), .LOCK_CNT(LOCK), .READY_CODE(4'h3), .STRETCH_W(SW)
  ) dut (
    .txusrclk2(txusrclk2),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 txusrclk2 = ~txusrclk2;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: lane mode 0=idle 1=hunt 2=locked; run = consecutive clean cycles seen while hunting.
  int mode  [NL];
  int run   [NL];
  int cnt   [NL];
  int blank [NL];
  int exp_cnt_out;
  logic [0:NL-1] exp_locked, exp_led;
  bit mdl_valid = 1'b0;

  always @(posedge txusrclk2) begin : model
    logic [0:NL-1] nl, nled;
    int base;
    if (reset) begin
      for (int i = 0; i < NL; i++) begin
        mode[i] = 0; run[i] = 0; cnt[i] = 0; blank[i] = 0;
      end
      exp_cnt_out = 0; exp_locked = '0; exp_led = '0;
      mdl_valid = 1'b1;
    end else begin
      exp_cnt_out = (int'(bus.sel_lane) < NL) ? cnt[bus.sel_lane] : 0;
      for (int i = 0; i < NL; i++) begin
        nl[i] = (mode[i] == 2);
`ifdef LED_ERR_STRETCH_EN
        nled[i] = exp_locked[i] && (blank[i] == 0);
`else
        nled[i] = exp_locked[i];
`endif
        base = bus.clear ? 0 : cnt[i];
        if (mode[i] == 2 && bus.PRBS_error[i]) cnt[i] = (base + 1 > MAXC) ? MAXC : base + 1;
        else cnt[i] = base;
        if (mode[i] == 2 && bus.PRBS_error[i]) blank[i] = BLANK;
        else if (blank[i] > 0) blank[i] = blank[i] - 1;
        if (bus.state_status != 4'h3) begin
          mode[i] = 0; run[i] = 0;
        end else if (mode[i] == 0) begin
          mode[i] = 1; run[i] = 0;
        end else if (mode[i] == 1) begin
          if (bus.PRBS_error[i]) run[i] = 0;
          else if (run[i] == LOCK) mode[i] = 2;
          else run[i] = run[i] + 1;
        end
      end
      exp_locked = nl;
      exp_led    = nled;
    end
  end

  always @(negedge txusrclk2) begin : compare
    if (mdl_valid) begin
      chk("cyc_err_count", int'(bus.err_count), exp_cnt_out);
      chk("cyc_lane_locked", int'(bus.lane_locked), int'(exp_locked));
      chk("cyc_led_fp", int'(bus.led_fp), int'(exp_led));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge txusrclk2);
  endtask

  task automatic drive_err(input int lane, input logic v);
    logic [0:NL-1] e;
    e = '0;
    if (lane >= 0) e[lane] = v;
    bus.PRBS_error = e;
  endtask

  initial begin : stim
    int low;
    bus.PRBS_error   = '0;
    bus.state_status = 4'h0;
    bus.clear        = 1'b0;
    bus.sel_lane     = 3'd0;
    tick(3);
    chk("rst_err_count", int'(bus.err_count), 0);
    chk("rst_lane_locked", int'(bus.lane_locked), 0);
    chk("rst_led_fp", int'(bus.led_fp), 0);

    // 1: clean link, lock after 255 clean HUNT cycles, flag 2 cycles later
    reset = 1'b0;
    bus.state_status = 4'h3;
    tick(257);
    chk("t1_not_yet_locked", int'(bus.lane_locked), 8'h00);
    tick(1);
    chk("t1_locked", int'(bus.lane_locked), 8'hFF);
    chk("t1_count0", int'(bus.err_count), 0);

    // 2: five pulses on lane 2
    bus.sel_lane = 3'd2;
    for (int k = 0; k < 5; k++) begin
      drive_err(2, 1'b1); tick(1);
      drive_err(-1, 1'b0); tick(1);
    end
    chk("t2_lane2_count", int'(bus.err_count), 5);
    for (int l = 0; l < NL; l++) begin
      if (l != 2) begin
        bus.sel_lane = 3'(l); tick(1);
        chk("t2_other_lane0", int'(bus.err_count), 0);
      end
    end

    // 3: link bounce, lane 0 error at clean count 200 restarts its hunt
    bus.state_status = 4'h0; tick(1);
    bus.state_status = 4'h3; tick(201);
    drive_err(0, 1'b1); tick(1);
    drive_err(-1, 1'b0);
    tick(256);
    chk("t3_lane0_hunting", int'(bus.lane_locked), 8'h7F);
    tick(1);
    chk("t3_lane0_locked", int'(bus.lane_locked), 8'hFF);
    bus.sel_lane = 3'd0; tick(1);
    chk("t3_hunt_err_dropped", int'(bus.err_count), 0);

    // 4: saturation at 15, then clear with coincident error
    bus.sel_lane = 3'd1;
    drive_err(1, 1'b1); tick(20);
    drive_err(-1, 1'b0); tick(2);
    chk("t4_saturated", int'(bus.err_count), 15);
    tick(3);
    chk("t4_held", int'(bus.err_count), 15);
    bus.clear = 1'b1; drive_err(1, 1'b1); tick(1);
    bus.clear = 1'b0; drive_err(-1, 1'b0); tick(1);
    chk("t4_clear_plus_err", int'(bus.err_count), 1);
    bus.sel_lane = 3'd2; tick(1);
    chk("t4_lane2_cleared", int'(bus.err_count), 0);

    // 5: link loss drops lock but keeps counts; reset wipes everything
    bus.sel_lane = 3'd1;
    bus.state_status = 4'h0; tick(2);
    chk("t5_unlocked", int'(bus.lane_locked), 8'h00);
    chk("t5_count_kept", int'(bus.err_count), 1);
    reset = 1'b1; tick(1);
    chk("t5_rst_count", int'(bus.err_count), 0);
    chk("t5_rst_led", int'(bus.led_fp), 0);
    reset = 1'b0; tick(1);
    chk("t5_count_gone", int'(bus.err_count), 0);

    // 6: LED behaviour after a single lane-7 error
    bus.state_status = 4'h3; tick(260);
    chk("t6_led_on", int'(bus.led_fp), 8'hFF);
    bus.sel_lane = 3'd7;
    drive_err(7, 1'b1); tick(1);
    drive_err(-1, 1'b0);
    low = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (!bus.led_fp[7]) low++;
    end
`ifdef LED_ERR_STRETCH_EN
    chk("t6_led7_blank_cycles", low, 15);
`else
    chk("t6_led7_blank_cycles", low, 0);
`endif
    chk("t6_lane7_count", int'(bus.err_count), 1);
    chk("t6_led_final", int'(bus.led_fp), 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
